wb_matmul_engine: RTL and testbench

Wishbone-slave signed matrix-multiply engine. It is the parametrised successor of the fixed square AI accelerator: element width and maximum dimension are parameters, operands may be rectangular, and it adds accumulate, saturate, status, cycle-count and interrupt features. A, B and C live in internal register arrays and are memory-mapped next to the control registers. One MAC is issued per clock.

---
 rtl/wb_matmul_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_wb_matmul_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_matmul_engine.sv
// wb_matmul_engine -- Wishbone-slave signed matrix-multiply engine.
//
// Computes C = A x B (optionally C += A x B) for an MxK by KxN product of
// signed DATA_W-bit elements, issuing one multiply-accumulate per clock.
// A, B and C live in internal register arrays mapped after eight control
// words: CTRL, W_A(K), H_A(M), W_B(N), H_B, GO, STATUS, CYCLES.
//
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   asynchronous, active-low reset
//   wb_stb     bus strobe
//   wb_we_i    1 = write
//   wb_addr_i  byte address (word index = (addr - BASE_ADDR) >> 2)
//   wb_data_i  write data
//   wb_data_o  read data, valid while wb_ack is high
//   wb_ack     one-cycle acknowledge
//   irq_o      level interrupt = STATUS.done & CTRL.irq_en
module wb_matmul_engine #(
    parameter int          DATA_W    = 16,
    parameter int          MAX_DIM   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3010_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_stb,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack,
    output logic        irq_o
);

    localparam int          DD     = MAX_DIM * MAX_DIM;
    localparam int          AW     = $clog2(DD);
    localparam int          ACC_W  = 2 * DATA_W + $clog2(MAX_DIM) + 1;
    localparam logic [31:0] A_BASE = 32'd8;
    localparam logic [31:0] B_BASE = 32'(8 + DD);
    localparam logic [31:0] C_BASE = 32'(8 + 2 * DD);
    localparam logic [31:0] C_END  = 32'(8 + 3 * DD);
    localparam logic [4:0]  MAX_D5 = 5'(MAX_DIM);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_INIT, S_MAC, S_WRITE, S_DONE
    } state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] a_mem [DD];
    logic signed [DATA_W-1:0] b_mem [DD];
    logic signed [DATA_W-1:0] c_mem [DD];

    logic [4:0]  ctrl, w_a, h_a, w_b, h_b;
    logic        busy, done, err;
    logic [31:0] cycles;
    logic [4:0]  i, j, k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] result;

    // Bus handshake: a transfer is accepted on the clock edge where wb_stb is
    // high, wb_ack is low and wb_stb has been seen low since the previous
    // transfer ('armed'). That same edge raises wb_ack for exactly one cycle,
    // performs the write and registers the read data.
    logic        armed, fire, wr_fire, go_fire;
    logic [31:0] w_idx, rd_val;
    logic        in_a, in_b, in_c;
    logic [AW-1:0] a_bus_idx, b_bus_idx, c_bus_idx;
    logic [AW-1:0] a_eng_idx, b_eng_idx, c_eng_idx;
    logic signed [ACC_W-1:0] a_ext, b_ext, c_ext;
    logic        dims_bad, i_last, j_last, k_last;
    logic        unused_data;

    assign w_idx   = (wb_addr_i - BASE_ADDR) >> 2;
    assign fire    = wb_stb && !wb_ack && armed;
    assign wr_fire = fire && wb_we_i;
    assign go_fire = wr_fire && !busy && (w_idx == 32'd5);

    assign in_a = (w_idx >= A_BASE) && (w_idx < B_BASE);
    assign in_b = (w_idx >= B_BASE) && (w_idx < C_BASE);
    assign in_c = (w_idx >= C_BASE) && (w_idx < C_END);
    assign a_bus_idx = AW'(w_idx - A_BASE);
    assign b_bus_idx = AW'(w_idx - B_BASE);
    assign c_bus_idx = AW'(w_idx - C_BASE);

    // Operands are packed row-major at the programmed dimensions.
    assign a_eng_idx = AW'(i) * AW'(w_a) + AW'(k);
    assign b_eng_idx = AW'(k) * AW'(w_b) + AW'(j);
    assign c_eng_idx = AW'(i) * AW'(w_b) + AW'(j);
    assign a_ext = ACC_W'(a_mem[a_eng_idx]);
    assign b_ext = ACC_W'(b_mem[b_eng_idx]);
    assign c_ext = ACC_W'(c_mem[c_eng_idx]);

    assign dims_bad = (w_a != h_b) || (h_a == 5'd0) || (w_a == 5'd0) || (w_b == 5'd0)
                   || (h_a > MAX_D5) || (w_a > MAX_D5) || (w_b > MAX_D5);
    assign i_last = (i == h_a - 5'd1);
    assign j_last = (j == w_b - 5'd1);
    assign k_last = (k == w_a - 5'd1);

    assign irq_o       = done & ctrl[2];
    assign unused_data = ^wb_data_i;

    always_comb begin
        result = acc[DATA_W-1:0];
        if (ctrl[1]) begin
            if (acc > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
            else if (acc < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
        end
    end

    always_comb begin
        rd_val = '0;
        if (in_a)      rd_val = 32'(a_mem[a_bus_idx]);
        else if (in_b) rd_val = 32'(b_mem[b_bus_idx]);
        else if (in_c) rd_val = 32'(c_mem[c_bus_idx]);
        else begin
            case (w_idx)
                32'd0:   rd_val = {27'd0, ctrl};
                32'd1:   rd_val = {27'd0, w_a};
                32'd2:   rd_val = {27'd0, h_a};
                32'd3:   rd_val = {27'd0, w_b};
                32'd4:   rd_val = {27'd0, h_b};
                32'd6:   rd_val = {29'd0, err, done, busy};
                32'd7:   rd_val = cycles;
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state <= S_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (go_fire) state_next = S_CHECK;
            S_CHECK: state_next = dims_bad ? S_IDLE : S_INIT;
            S_INIT:  state_next = S_MAC;
            S_MAC:   if (k_last) state_next = S_WRITE;
            S_WRITE: state_next = (i_last && j_last) ? S_DONE : S_INIT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            armed     <= 1'b1;
            wb_ack    <= 1'b0;
            wb_data_o <= '0;
            ctrl      <= '0;
            w_a       <= '0;
            h_a       <= '0;
            w_b       <= '0;
            h_b       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cycles    <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
        end else begin
            if (!wb_stb)   armed <= 1'b1;
            else if (fire) armed <= 1'b0;
            wb_ack    <= fire;
            wb_data_o <= (fire && !wb_we_i) ? rd_val : '0;

            if (busy && cycles != '1) cycles <= cycles + 32'd1;

            // Configuration is frozen while a run is in progress.
            if (wr_fire && !busy) begin
                case (w_idx)
                    32'd0: ctrl <= wb_data_i[4:0];
                    32'd1: w_a  <= wb_data_i[4:0];
                    32'd2: h_a  <= wb_data_i[4:0];
                    32'd3: w_b  <= wb_data_i[4:0];
                    32'd4: h_b  <= wb_data_i[4:0];
                    32'd5: begin
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        err    <= 1'b0;
                        cycles <= '0;
                    end
                    default: ;
                endcase
            end

            if (wr_fire && w_idx == 32'd6) begin
                if (wb_data_i[1]) done <= 1'b0;
                if (wb_data_i[2]) err  <= 1'b0;
            end

            // Engine updates come after the W1C so a same-cycle DONE wins.
            case (state)
                S_CHECK: begin
                    if (dims_bad) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        i <= '0;
                        j <= '0;
                    end
                end
                S_INIT: begin
                    acc <= ctrl[0] ? c_ext : '0;
                    k   <= '0;
                end
                S_MAC: begin
                    acc <= acc + a_ext * b_ext;
                    k   <= k + 5'd1;
                end
                S_WRITE: begin
                    if (j_last) begin
                        j <= '0;
                        i <= i + 5'd1;
                    end else begin
                        j <= j + 5'd1;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand/result arrays are deliberately not reset.
    always_ff @(posedge wb_clk_i) begin
        if (wr_fire && !busy && in_a) a_mem[a_bus_idx] <= wb_data_i[DATA_W-1:0];
        if (wr_fire && !busy && in_b) b_mem[b_bus_idx] <= wb_data_i[DATA_W-1:0];
        if (state == S_WRITE)                c_mem[c_eng_idx] <= result;
        else if (wr_fire && !busy && in_c)   c_mem[c_bus_idx] <= wb_data_i[DATA_W-1:0];
    end

endmodule

// File: tb/tb_wb_matmul_engine.sv
// Self-checking bench for wb_matmul_engine (DATA_W=16, MAX_DIM=16).
module tb_wb_matmul_engine;

    localparam logic [31:0] BASE = 32'h3010_0000;
    localparam int A_W = 8;
    localparam int B_W = 8 + 256;
    localparam int C_W = 8 + 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_stb, wb_we_i;
    logic [31:0] wb_addr_i, wb_data_i, wb_data_o;
    logic        wb_ack, irq_o;

    wb_matmul_engine #(.DATA_W(16), .MAX_DIM(16), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_stb   (wb_stb),
        .wb_we_i  (wb_we_i),
        .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i),
        .wb_data_o(wb_data_o),
        .wb_ack   (wb_ack),
        .irq_o    (irq_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic        rd_chk = 1'b0;
    logic        prev_ack = 1'b0;
    int          last_ack_cyc = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] s(input int v);
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    int          ma[256], mb[256], mc[256];
    logic [4:0]  m_ctrl, m_wa, m_ha, m_wb, m_hb;
    logic        m_done, m_err, m_busy;
    logic [31:0] m_cycles;

    function automatic void model_reset();
        m_ctrl = 0; m_wa = 0; m_ha = 0; m_wb = 0; m_hb = 0;
        m_done = 0; m_err = 0; m_busy = 0; m_cycles = 0;
    endfunction

    function automatic void model_go();
        int M, K, N;
        longint acc;
        logic signed [15:0] t;
        M = m_ha; K = m_wa; N = m_wb;
        m_done = 0; m_err = 0; m_busy = 1;
        if (K != int'(m_hb) || M == 0 || K == 0 || N == 0 || M > 16 || K > 16 || N > 16) begin
            m_err = 1;
            m_cycles = 1;
        end else begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) begin
                    acc = m_ctrl[0] ? longint'(mc[r*N+c]) : 0;
                    for (int x = 0; x < K; x++)
                        acc += longint'(ma[r*K+x]) * longint'(mb[x*N+c]);
                    if (m_ctrl[1] && acc > 32767)       mc[r*N+c] = 32767;
                    else if (m_ctrl[1] && acc < -32768) mc[r*N+c] = -32768;
                    else begin
                        t = acc[15:0];
                        mc[r*N+c] = t;
                    end
                end
            m_done = 1;
            m_cycles = 32'(M * N * (K + 2) + 2);
        end
    endfunction

    function automatic void model_write(input int w, input logic [31:0] d);
        logic signed [15:0] e;
        e = d[15:0];
        if (w == 6) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_err = 0;
        end else if (!m_busy) begin
            case (w)
                0: m_ctrl = d[4:0];
                1: m_wa = d[4:0];
                2: m_ha = d[4:0];
                3: m_wb = d[4:0];
                4: m_hb = d[4:0];
                5: model_go();
                default: begin
                    if (w >= A_W && w < B_W)      ma[w-A_W] = e;
                    else if (w >= B_W && w < C_W) mb[w-B_W] = e;
                    else if (w >= C_W && w < C_W + 256) mc[w-C_W] = e;
                end
            endcase
        end
    endfunction

    function automatic logic [31:0] model_read(input int w);
        case (w)
            0: return {27'd0, m_ctrl};
            1: return {27'd0, m_wa};
            2: return {27'd0, m_ha};
            3: return {27'd0, m_wb};
            4: return {27'd0, m_hb};
            6: return {29'd0, m_err, m_done, m_busy};
            7: return m_cycles;
            default: begin
                if (w >= A_W && w < B_W)      return s(ma[w-A_W]);
                if (w >= B_W && w < C_W)      return s(mb[w-B_W]);
                if (w >= C_W && w < C_W + 256) return s(mc[w-C_W]);
                return 32'd0;
            end
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (wb_ack) begin
            check("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
            last_ack_cyc = cyc;
            if (!wb_we_i && rd_chk) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_unexpected: got 0x%08h expected no read", wb_data_o);
                end else begin
                    check(nm_q.pop_front(), wb_data_o, exp_q.pop_front());
                end
            end
        end
        prev_ack = wb_ack;
    end

    // ---------------- driver tasks ----------------
    task automatic bus_xfer(input logic [31:0] addr, input logic we, input logic [31:0] d,
                            input logic chk);
        int t;
        @(negedge clk);
        wb_addr_i = addr; wb_we_i = we; wb_data_i = d; rd_chk = chk; wb_stb = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wb_ack && t < 16);
        if (!wb_ack) begin
            n_tests++; n_fail++;
            $display("FAIL ack_timeout: got no ack at addr 0x%08h expected ack within 16 cycles", addr);
        end
        wb_stb = 1'b0;
    endtask

    task automatic wr(input int w, input logic [31:0] d);
        bus_xfer(BASE + 32'(w) * 4, 1'b1, d, 1'b0);
        model_write(w, d);
    endtask

    task automatic rd(input int w, input string nm);
        exp_q.push_back(model_read(w));
        nm_q.push_back(nm);
        bus_xfer(BASE + 32'(w) * 4, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic rd_lit(input int w, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        bus_xfer(BASE + 32'(w) * 4, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic set_dims(input int m, input int k, input int n, input int hb);
        wr(1, s(k)); wr(2, s(m)); wr(3, s(n)); wr(4, s(hb));
    endtask

    task automatic go_and_wait();
        wr(5, 32'd0);
        repeat (int'(m_cycles) + 4) @(posedge clk);
        m_busy = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int m, k, n, hb, kind;
        wb_stb = 0; wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
        for (int x = 0; x < 256; x++) begin ma[x] = 0; mb[x] = 0; mc[x] = 0; end
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {31'd0, wb_ack}, 32'd0);
        check("reset_data", wb_data_o, 32'd0);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < 8; w++) rd_lit(w, 32'd0, "reset_reg");
        wr(800, 32'h1234);
        rd_lit(800, 32'd0, "unmapped_read");
        bus_xfer(BASE - 32'd4, 1'b0, 32'd0, 1'b0);

        for (int x = 0; x < 16; x++) begin
            wr(A_W + x, $urandom_range(0, 65535));
            wr(B_W + x, $urandom_range(0, 65535));
            wr(C_W + x, $urandom_range(0, 65535));
        end
        rd(A_W + 3, "a_readback");
        rd(C_W + 5, "c_readback");

        // 2x2 signed product
        wr(0, 0);
        set_dims(2, 2, 2, 2);
        wr(A_W + 0, s(-3)); wr(A_W + 1, s(-15)); wr(A_W + 2, s(-6)); wr(A_W + 3, s(7));
        wr(B_W + 0, s(9));  wr(B_W + 1, s(-15)); wr(B_W + 2, s(-2)); wr(B_W + 3, s(-5));
        go_and_wait();
        check("model_c00", s(mc[0]), s(3));
        check("model_c11", s(mc[3]), s(55));
        rd_lit(C_W + 0, s(3), "c2x2_00");
        rd_lit(C_W + 1, s(120), "c2x2_01");
        rd_lit(C_W + 2, s(-68), "c2x2_10");
        rd_lit(C_W + 3, s(55), "c2x2_11");
        rd_lit(6, 32'h2, "c2x2_status");
        rd_lit(7, 32'd18, "c2x2_cycles");

        // accumulate, with an ignored A write while busy
        wr(0, 1);
        wr(5, 32'd0);
        wr(A_W + 0, s(99));
        repeat (int'(m_cycles) + 4) @(posedge clk);
        m_busy = 0;
        rd_lit(C_W + 0, s(6), "acc_00");
        rd_lit(C_W + 1, s(240), "acc_01");
        rd_lit(C_W + 2, s(-136), "acc_10");
        rd_lit(C_W + 3, s(110), "acc_11");
        rd_lit(A_W + 0, 32'hFFFF_FFFD, "busy_write_ignored");

        // rectangular 2x3 * 3x1
        wr(0, 0);
        set_dims(2, 3, 1, 3);
        wr(A_W + 0, s(1));  wr(A_W + 1, s(2)); wr(A_W + 2, s(3));
        wr(A_W + 3, s(-4)); wr(A_W + 4, s(5)); wr(A_W + 5, s(-6));
        wr(B_W + 0, s(7));  wr(B_W + 1, s(8)); wr(B_W + 2, s(9));
        go_and_wait();
        check("model_rect0", s(mc[0]), s(50));
        rd_lit(C_W + 0, s(50), "rect_0");
        rd_lit(C_W + 1, s(-42), "rect_1");
        rd_lit(7, 32'd12, "rect_cycles");

        // dimension error
        wr(4, 2);
        go_and_wait();
        rd_lit(6, 32'h4, "err_status");
        rd_lit(C_W + 0, s(50), "err_c_untouched");
        rd(7, "err_cycles");
        wr(6, 32'h4);
        rd_lit(6, 32'h0, "err_w1c");

        // saturation boundary
        set_dims(1, 1, 1, 1);
        wr(A_W + 0, s(32767)); wr(B_W + 0, s(2));
        wr(0, 2);
        go_and_wait();
        rd_lit(C_W + 0, s(32767), "sat_on");
        wr(0, 0);
        go_and_wait();
        rd_lit(C_W + 0, 32'hFFFF_FFFE, "sat_off");

        // randomized runs against the model
        for (int r = 0; r < 10; r++) begin
            m = $urandom_range(1, 4); k = $urandom_range(1, 4); n = $urandom_range(1, 4);
            hb = k;
            kind = $urandom_range(0, 7);
            if (kind == 0) hb = k + 1;
            else if (kind == 1) m = 0;
            else if (kind == 2) n = 17;
            set_dims(m, k, n, hb);
            wr(0, $urandom_range(0, 3));
            for (int x = 0; x < 16; x++) begin
                wr(A_W + x, $urandom_range(0, 65535));
                wr(B_W + x, $urandom_range(0, 65535));
            end
            go_and_wait();
            rd(6, "rand_status");
            rd(7, "rand_cycles");
            rd(0, "rand_ctrl");
            for (int x = 0; x < 16; x++) rd(C_W + x, "rand_c");
            wr(6, 32'h6);
        end

        // interrupt timing and clear
        set_dims(2, 2, 2, 2);
        wr(0, 4);
        wr(5, 32'd0);
        while (cyc < last_ack_cyc + int'(m_cycles) - 1) @(negedge clk);
        check("irq_before_done", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        check("irq_at_done", {31'd0, irq_o}, 32'd1);
        m_busy = 0;
        rd(6, "irq_status");
        wr(6, 32'h2);
        check("irq_after_w1c", {31'd0, irq_o}, 32'd0);
        rd_lit(6, 32'h0, "irq_status_clear");

        // reset in the middle of a run
        wr(5, 32'd0);
        while (cyc < last_ack_cyc + 5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_rst_ack", {31'd0, wb_ack}, 32'd0);
        check("midrun_rst_irq", {31'd0, irq_o}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_lit(6, 32'h0, "midrun_status");
        rd_lit(0, 32'h0, "midrun_ctrl");
        rd_lit(7, 32'h0, "midrun_cycles");

        repeat (3) @(posedge clk);
        check("queue_drained", s(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000 ns");
        $fatal(1, "watchdog");
    end

endmodule
